gpio_pattern_seq: RTL and testbench



---
 rtl/gpio_pattern_seq.sv | 192 +++++++++++++++++++
 tb/tb_gpio_pattern_seq.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pattern_seq
// Purpose  : Table-driven GPIO pattern sequencer with per-entry dwell and
//            loop control. Optional input capture via GPIO_PATTERN_SEQ_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_pattern_seq #(
  parameter int                        GPIO_REG_WIDTH = 12,
  parameter int                        DEPTH          = 16,
  parameter int                        DWELL_WIDTH    = 16,
  parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK       = 12'hD55,
  parameter logic [GPIO_REG_WIDTH-1:0] IDLE_VAL       = 12'h000,
  localparam int                       ADDR_W         = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [GPIO_REG_WIDTH-1:0] cfg_data,
  input  logic [DWELL_WIDTH-1:0]    cfg_dwell,
  input  logic [ADDR_W:0]           num_steps,
  input  logic [7:0]                loop_count,
  input  logic                      start,
  input  logic                      stop,
  output logic [GPIO_REG_WIDTH-1:0] gpio_out,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         step_idx,
`ifdef GPIO_PATTERN_SEQ_CAPTURE_EN
  output logic [GPIO_REG_WIDTH-1:0] cap_data,
  output logic                      cap_valid,
`endif
  input  logic [GPIO_REG_WIDTH-1:0] gpio_in
);

  localparam logic [GPIO_REG_WIDTH-1:0] c_idle_word = IDLE_VAL & OUT_MASK;
  localparam logic [ADDR_W:0]           c_num_one   = 1;
  localparam logic [ADDR_W-1:0]         c_step_one  = 1;
  localparam logic [DWELL_WIDTH-1:0]    c_dwell_one = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [GPIO_REG_WIDTH-1:0] r_tbl_data  [DEPTH];
  logic [DWELL_WIDTH-1:0]    r_tbl_dwell [DEPTH];
  logic [DWELL_WIDTH-1:0]    r_dwell_cnt;
  logic [7:0]                r_pass_cnt;
  logic [ADDR_W:0]           r_num_steps;
  logic [7:0]                r_loop_count;

  state_t                    w_state_nxt;
  logic [GPIO_REG_WIDTH-1:0] w_gpio_nxt;
  logic                      w_busy_nxt;
  logic                      w_done_nxt;
  logic [ADDR_W-1:0]         w_step_nxt;
  logic [DWELL_WIDTH-1:0]    w_dwell_nxt;
  logic [7:0]                w_pass_nxt;
  logic [ADDR_W:0]           w_num_nxt;
  logic [7:0]                w_loop_nxt;
  logic                      w_last_step;
  logic                      w_last_pass;
  logic [ADDR_W-1:0]         w_fetch_idx;
  logic [GPIO_REG_WIDTH-1:0] w_fetch_data;
  logic [DWELL_WIDTH-1:0]    w_fetch_dwell;

  // Table has no reset so contents survive a reset of the sequencer.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      r_tbl_data[cfg_addr]  <= cfg_data;
      r_tbl_dwell[cfg_addr] <= cfg_dwell;
    end
  end

  assign w_last_step = ({1'b0, step_idx} == (r_num_steps - c_num_one));
  assign w_last_pass = (r_loop_count != 8'd0) && ((r_pass_cnt + 8'd1) == r_loop_count);

  // The only entry ever fetched is the next one, or entry 0 on start/wrap.
  assign w_fetch_idx   = ((r_state == S_RUN) && !w_last_step) ? (step_idx + c_step_one) : '0;
  assign w_fetch_data  = r_tbl_data[w_fetch_idx];
  assign w_fetch_dwell = r_tbl_dwell[w_fetch_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_gpio_nxt  = gpio_out;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
    w_step_nxt  = step_idx;
    w_dwell_nxt = r_dwell_cnt;
    w_pass_nxt  = r_pass_cnt;
    w_num_nxt   = r_num_steps;
    w_loop_nxt  = r_loop_count;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (num_steps != '0) begin
            w_state_nxt = S_RUN;
            w_num_nxt   = num_steps;
            w_loop_nxt  = loop_count;
            w_pass_nxt  = 8'd0;
            w_step_nxt  = '0;
            w_gpio_nxt  = w_fetch_data & OUT_MASK;
            w_dwell_nxt = w_fetch_dwell;
            w_busy_nxt  = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_gpio_nxt  = c_idle_word;
          w_busy_nxt  = 1'b0;
          w_step_nxt  = '0;
        end else if (r_dwell_cnt != '0) begin
          w_dwell_nxt = r_dwell_cnt - c_dwell_one;
        end else if (w_last_step && w_last_pass) begin
          w_state_nxt = S_FIN;
          w_gpio_nxt  = c_idle_word;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_step_nxt  = '0;
        end else begin
          if (w_last_step) begin
            w_pass_nxt = r_pass_cnt + 8'd1;
          end
          w_step_nxt  = w_fetch_idx;
          w_gpio_nxt  = w_fetch_data & OUT_MASK;
          w_dwell_nxt = w_fetch_dwell;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gpio_nxt  = c_idle_word;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      gpio_out     <= c_idle_word;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_idx     <= '0;
      r_dwell_cnt  <= '0;
      r_pass_cnt   <= 8'd0;
      r_num_steps  <= '0;
      r_loop_count <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      gpio_out     <= w_gpio_nxt;
      busy         <= w_busy_nxt;
      done         <= w_done_nxt;
      step_idx     <= w_step_nxt;
      r_dwell_cnt  <= w_dwell_nxt;
      r_pass_cnt   <= w_pass_nxt;
      r_num_steps  <= w_num_nxt;
      r_loop_count <= w_loop_nxt;
    end
  end

`ifdef GPIO_PATTERN_SEQ_CAPTURE_EN
  // Sample the pins in the final dwell cycle of every step.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      if ((r_state == S_RUN) && (r_dwell_cnt == '0)) begin
        cap_data  <= gpio_in;
        cap_valid <= 1'b1;
      end
    end
  end
`else
  logic w_unused_gpio_in;
  assign w_unused_gpio_in = ^gpio_in;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_pattern_seq
// Purpose  : Self-checking bench for gpio_pattern_seq against a trace model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_pattern_seq;

  localparam int W  = 12;
  localparam int D  = 16;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam logic [W-1:0] MASK = 12'hD55;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic [DW-1:0] cfg_dwell;
  logic [AW:0]   num_steps;
  logic [7:0]    loop_count;
  logic          start;
  logic          stop;
  logic [W-1:0]  gpio_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;
  logic [W-1:0]  gpio_in;
`ifdef GPIO_PATTERN_SEQ_CAPTURE_EN
  logic [W-1:0]  cap_data;
  logic          cap_valid;
`endif

  int checks   = 0;
  int failures = 0;

  // Model of the table contents and the expected per-cycle output trace.
  logic [W-1:0]  m_data  [D];
  int            m_dwell [D];
  logic [W-1:0]  exp_out [$];
  logic [AW-1:0] exp_idx [$];

  always #5 clk = ~clk;

  gpio_pattern_seq dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_dwell  (cfg_dwell),
    .num_steps  (num_steps),
    .loop_count (loop_count),
    .start      (start),
    .stop       (stop),
    .gpio_out   (gpio_out),
    .busy       (busy),
    .done       (done),
    .step_idx   (step_idx),
`ifdef GPIO_PATTERN_SEQ_CAPTURE_EN
    .cap_data   (cap_data),
    .cap_valid  (cap_valid),
`endif
    .gpio_in    (gpio_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input int dw);
    cfg_we    = 1'b1;
    cfg_addr  = a[AW-1:0];
    cfg_data  = d;
    cfg_dwell = dw[DW-1:0];
    tick();
    cfg_we    = 1'b0;
    m_data[a]  = d;
    m_dwell[a] = dw;
  endtask

  task automatic load_basic();
    wr(0, 12'hFFF, 0);
    wr(1, 12'h0F0, 2);
    wr(2, 12'h555, 1);
  endtask

  // Each pass plays entries 0..n-1, each visible for dwell+1 cycles.
  function automatic void build(input int n, input int loops);
    for (int p = 0; p < loops; p++)
      for (int i = 0; i < n; i++)
        for (int c = 0; c <= m_dwell[i]; c++) begin
          exp_out.push_back(m_data[i] & MASK);
          exp_idx.push_back(i[AW-1:0]);
        end
  endfunction

  task automatic go(input int n, input int loops);
    num_steps  = n[AW:0];
    loop_count = loops[7:0];
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (gpio_out !== 12'h000 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_values gpio=%h busy=%b done=%b idx=%0d required gpio=000 busy=0 done=0 idx=0",
               gpio_out, busy, done, step_idx);
    end
`ifdef GPIO_PATTERN_SEQ_CAPTURE_EN
    checks++;
    if (cap_data !== 12'h000 || cap_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_cap cap_data=%h cap_valid=%b required 000/0", cap_data, cap_valid);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int busy_cycles = 0;
    load_basic();
    exp_out.delete(); exp_idx.delete();
    build(3, 1);
    go(3, 1);
    for (int k = 0; k < exp_out.size(); k++) begin
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (gpio_out !== exp_out[k] || step_idx !== exp_idx[k] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL basic_step k=%0d gpio=%h idx=%0d busy=%b done=%b required gpio=%h idx=%0d busy=1 done=0",
                 k, gpio_out, step_idx, busy, done, exp_out[k], exp_idx[k]);
      end
      tick();
    end
    checks++;
    if (gpio_out !== 12'h000 || busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL basic_fin gpio=%h busy=%b done=%b required 000/0/1", gpio_out, busy, done);
    end
    checks++;
    if (busy_cycles !== 6) begin
      failures++;
      $display("FAIL basic_busy_len busy_cycles=%0d required 6", busy_cycles);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_after done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_loops();
    int done_cnt = 0;
    exp_out.delete(); exp_idx.delete();
    build(3, 2);
    go(3, 2);
    for (int k = 0; k < exp_out.size(); k++) begin
      checks++;
      if (gpio_out !== exp_out[k] || step_idx !== exp_idx[k] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL loops_step k=%0d gpio=%h idx=%0d busy=%b done=%b required gpio=%h idx=%0d busy=1 done=0",
                 k, gpio_out, step_idx, busy, done, exp_out[k], exp_idx[k]);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL loops_done_count done_pulses=%0d required 1", done_cnt);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int n     = $urandom_range(16, 1);
      int loops = $urandom_range(3, 1);
      for (int a = 0; a < D; a++) wr(a, W'($urandom), $urandom_range(3, 0));
      exp_out.delete(); exp_idx.delete();
      build(n, loops);
      go(n, loops);
      for (int k = 0; k < exp_out.size(); k++) begin
        checks++;
        if (gpio_out !== exp_out[k] || step_idx !== exp_idx[k] || busy !== 1'b1) begin
          failures++;
          $display("FAIL random_step r=%0d k=%0d gpio=%h idx=%0d busy=%b required gpio=%h idx=%0d busy=1",
                   r, k, gpio_out, step_idx, busy, exp_out[k], exp_idx[k]);
        end
        tick();
      end
      checks++;
      if (gpio_out !== 12'h000 || busy !== 1'b0 || done !== 1'b1) begin
        failures++;
        $display("FAIL random_fin r=%0d gpio=%h busy=%b done=%b required 000/0/1", r, gpio_out, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_stop_infinite();
    int done_cnt = 0;
    load_basic();
    exp_out.delete(); exp_idx.delete();
    build(3, 8);
    go(3, 0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (gpio_out !== exp_out[k] || step_idx !== exp_idx[k] || busy !== 1'b1) begin
        failures++;
        $display("FAIL inf_step k=%0d gpio=%h idx=%0d busy=%b required gpio=%h idx=%0d busy=1",
                 k, gpio_out, step_idx, busy, exp_out[k], exp_idx[k]);
      end
      if (k == 19) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    checks++;
    if (gpio_out !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL inf_stop gpio=%h busy=%b done=%b required 000/0/0", gpio_out, busy, done);
    end
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("FAIL inf_no_done done_pulses=%0d required 0", done_cnt);
    end
  endtask

  task automatic test_edge();
    go(0, 1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gpio_out !== 12'h000) begin
      failures++;
      $display("FAIL zero_steps done=%b busy=%b gpio=%h required 1/0/000", done, busy, gpio_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_steps_after done=%b busy=%b required 0/0", done, busy);
    end
    num_steps = 5'd3; loop_count = 8'd1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || gpio_out !== 12'h000) begin
        failures++;
        $display("FAIL start_stop k=%0d busy=%b done=%b gpio=%h required 0/0/000", k, busy, done, gpio_out);
      end
      tick();
    end
    exp_out.delete(); exp_idx.delete();
    build(3, 1);
    go(3, 1);
    for (int k = 0; k < exp_out.size(); k++) begin
      if (k == 3) start = 1'b0;
      checks++;
      if (gpio_out !== exp_out[k] || step_idx !== exp_idx[k] || busy !== 1'b1) begin
        failures++;
        $display("FAIL start_busy k=%0d gpio=%h idx=%0d busy=%b required gpio=%h idx=%0d busy=1",
                 k, gpio_out, step_idx, busy, exp_out[k], exp_idx[k]);
      end
      if (k == 2) begin
        start = 1'b1; num_steps = 5'd1; loop_count = 8'd5;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_busy_fin done=%b busy=%b required 1/0", done, busy);
    end
    tick();
  endtask

  task automatic test_live_write();
    exp_out.delete(); exp_idx.delete();
    build(3, 1);
    m_data[1] = 12'h001;
    build(3, 1);
    go(3, 2);
    for (int k = 0; k < exp_out.size(); k++) begin
      if (k == 3) cfg_we = 1'b0;
      checks++;
      if (gpio_out !== exp_out[k] || step_idx !== exp_idx[k] || busy !== 1'b1) begin
        failures++;
        $display("FAIL live_write k=%0d gpio=%h idx=%0d busy=%b required gpio=%h idx=%0d busy=1",
                 k, gpio_out, step_idx, busy, exp_out[k], exp_idx[k]);
      end
      if (k == 2) begin
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 12'h001; cfg_dwell = 16'd2;
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL live_write_fin done=%b busy=%b required 1/0", done, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    load_basic();
    go(3, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (gpio_out !== 12'h000 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid gpio=%h busy=%b done=%b idx=%0d required 000/0/0/0",
               gpio_out, busy, done, step_idx);
    end
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done done_pulses=%0d required 0", done_cnt);
    end
    // Table contents must survive the reset.
    exp_out.delete(); exp_idx.delete();
    build(3, 1);
    go(3, 1);
    for (int k = 0; k < exp_out.size(); k++) begin
      checks++;
      if (gpio_out !== exp_out[k] || step_idx !== exp_idx[k]) begin
        failures++;
        $display("FAIL table_persist k=%0d gpio=%h idx=%0d required gpio=%h idx=%0d",
                 k, gpio_out, step_idx, exp_out[k], exp_idx[k]);
      end
      tick();
    end
    tick();
  endtask

`ifdef GPIO_PATTERN_SEQ_CAPTURE_EN
  task automatic test_capture();
    logic prev_end = 1'b0;
    gpio_in = 12'h022;
    exp_out.delete(); exp_idx.delete();
    build(3, 1);
    go(3, 1);
    for (int k = 0; k <= exp_out.size(); k++) begin
      checks++;
      if (cap_valid !== prev_end || (prev_end && cap_data !== 12'h022)) begin
        failures++;
        $display("FAIL capture k=%0d cap_valid=%b cap_data=%h required valid=%b data=022",
                 k, cap_valid, cap_data, prev_end);
      end
      if (k < exp_out.size())
        prev_end = (k == exp_out.size() - 1) || (exp_idx[k] !== exp_idx[k+1]);
      else
        prev_end = 1'b0;
      tick();
    end
    gpio_in = 12'h000;
  endtask
`endif

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_dwell = '0;
    num_steps = '0; loop_count = '0; start = 1'b0; stop = 1'b0; gpio_in = '0;
    test_reset();
    test_basic();
    test_loops();
    test_random();
    test_stop_infinite();
    test_edge();
    test_live_write();
    test_reset_mid();
`ifdef GPIO_PATTERN_SEQ_CAPTURE_EN
    test_capture();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
